// File: rtl/gf180mcu_fd_sc_mcu9t5v0__idle_det4_pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__idle_det4_pkg
// Shared definitions for the four-input idle detector: FSM state encoding,
// default synchroniser depth and hold length, and the wake counter width
// with its saturating increment helper.
// -----------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu9t5v0__idle_det4_pkg;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'b00,
        ST_SETTLE = 2'b01,
        ST_IDLE   = 2'b10
    } state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_HOLD_CYCLES = 8;
    localparam int WAKE_CNT_W      = 8;

    localparam logic [WAKE_CNT_W-1:0] WAKE_CNT_MAX = '1;

    // Saturating increment: holds at all-ones instead of wrapping to zero.
    function automatic logic [WAKE_CNT_W-1:0] sat_inc(input logic [WAKE_CNT_W-1:0] v);
        if (v == WAKE_CNT_MAX) begin
            return v;
        end
        return v + 1'b1;
    endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__idle_det4_sync.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__idle_det4_sync
// Parameterised 1-bit synchroniser chain. Every flop resets to 1 so that a
// line is considered active until real samples have flushed the chain.
//
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_d      asynchronous input bit
//   o_q      synchronised output (last stage of the chain)
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__idle_det4_sync
    import gf180mcu_fd_sc_mcu9t5v0__idle_det4_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chain <= '1;
        end else begin
            r_chain <= {r_chain[SYNC_STAGES-2:0], i_d};
        end
    end

    assign o_q = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__idle_det4.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__idle_det4
// Four-input idle detector. Each activity line is synchronised, the four
// synchronised bits are NOR-ed into Z, and an ACTIVE/SETTLE/IDLE FSM requires
// Z high for HOLD_CYCLES consecutive enabled cycles before declaring idle.
// Leaving idle because of input activity produces a one-cycle WAKE pulse and
// bumps a saturating WAKE counter; leaving because EN dropped does not.
//
// Ports:
//   CLK       clock, rising edge
//   RN        asynchronous active-low reset
//   A1..A4    asynchronous activity lines, high = active
//   EN        synchronous detector enable
//   IDLE      registered, high while in the IDLE state
//   WAKE      registered one-cycle pulse on activity-caused idle exit
//   WAKE_CNT  registered saturating count of WAKE pulses
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__idle_det4
    import gf180mcu_fd_sc_mcu9t5v0__idle_det4_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RN,
    input  logic                  A1,
    input  logic                  A2,
    input  logic                  A3,
    input  logic                  A4,
    input  logic                  EN,
    output logic                  IDLE,
    output logic                  WAKE,
    output logic [WAKE_CNT_W-1:0] WAKE_CNT
);

    // Counter only ever reaches HOLD_CYCLES-1.
    localparam int               CNT_W    = $clog2(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [3:0] w_a_async;
    logic [3:0] w_a_sync;
    logic       w_z;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wake;
    logic [WAKE_CNT_W-1:0] r_wake_cnt;

    state_t                w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic                  w_wake_nxt;
    logic [WAKE_CNT_W-1:0] w_wake_cnt_nxt;

    assign w_a_async = {A4, A3, A2, A1};

    for (genvar g = 0; g < 4; g++) begin : gen_sync
        gf180mcu_fd_sc_mcu9t5v0__idle_det4_sync #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync (
            .i_clk   (CLK),
            .i_rst_n (RN),
            .i_d     (w_a_async[g]),
            .o_q     (w_a_sync[g])
        );
    end

    assign w_z = ~|w_a_sync;

    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            r_state    <= ST_ACTIVE;
            r_cnt      <= '0;
            r_wake     <= 1'b0;
            r_wake_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_wake     <= w_wake_nxt;
            r_wake_cnt <= w_wake_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = ST_ACTIVE;
        w_cnt_nxt      = '0;
        w_wake_nxt     = 1'b0;
        w_wake_cnt_nxt = r_wake_cnt;
        case (r_state)
            ST_ACTIVE: begin
                if (EN && w_z) begin
                    w_state_nxt = ST_SETTLE;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_SETTLE: begin
                if (EN && w_z) begin
                    if (r_cnt == CNT_LAST) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_SETTLE;
                        w_cnt_nxt   = r_cnt + 1'b1;
                    end
                end
            end
            ST_IDLE: begin
                // EN low wins over activity: drop out quietly, no WAKE.
                if (EN && w_z) begin
                    w_state_nxt = ST_IDLE;
                end else if (EN) begin
                    w_wake_nxt     = 1'b1;
                    w_wake_cnt_nxt = sat_inc(r_wake_cnt);
                end
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
            end
        endcase
    end

    assign IDLE     = (r_state == ST_IDLE);
    assign WAKE     = r_wake;
    assign WAKE_CNT = r_wake_cnt;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__idle_det4.sv
// -----------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu9t5v0__idle_det4
// Directed bench for the idle detector with SYNC_STAGES=2, HOLD_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__idle_det4;

    logic       CLK;
    logic       RN;
    logic       A1, A2, A3, A4;
    logic       EN;
    logic       IDLE;
    logic       WAKE;
    logic [7:0] WAKE_CNT;

    int checks = 0;
    int errors = 0;

    gf180mcu_fd_sc_mcu9t5v0__idle_det4 #(
        .SYNC_STAGES (2),
        .HOLD_CYCLES (4)
    ) dut (
        .CLK      (CLK),
        .RN       (RN),
        .A1       (A1),
        .A2       (A2),
        .A3       (A3),
        .A4       (A4),
        .EN       (EN),
        .IDLE     (IDLE),
        .WAKE     (WAKE),
        .WAKE_CNT (WAKE_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Checks IDLE low on edges 1..5 and high on edge 6 with WAKE quiet.
    task automatic qualify(input string tag);
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk({tag, "_idle_low"}, {7'd0, IDLE}, 8'd0);
        end
        tick();
        chk({tag, "_idle_high"}, {7'd0, IDLE}, 8'd1);
        chk({tag, "_wake_quiet"}, {7'd0, WAKE}, 8'd0);
    endtask

    initial begin
        RN = 1'b0; A1 = 1'b0; A2 = 1'b0; A3 = 1'b0; A4 = 1'b0; EN = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_idle", {7'd0, IDLE}, 8'd0);
        chk("rst_wake", {7'd0, WAKE}, 8'd0);
        chk("rst_cnt", WAKE_CNT, 8'd0);

        // Startup: IDLE after the 6th edge following release
        RN = 1'b1;
        qualify("startup");

        // Wake on A1: three edges of latency
        A1 = 1'b1;
        tick();
        chk("wake_e1_idle", {7'd0, IDLE}, 8'd1);
        tick();
        chk("wake_e2_idle", {7'd0, IDLE}, 8'd1);
        chk("wake_e2_wake", {7'd0, WAKE}, 8'd0);
        tick();
        chk("wake_e3_idle", {7'd0, IDLE}, 8'd0);
        chk("wake_e3_wake", {7'd0, WAKE}, 8'd1);
        chk("wake_e3_cnt", WAKE_CNT, 8'd1);
        tick();
        chk("wake_e4_wake", {7'd0, WAKE}, 8'd0);
        chk("wake_e4_cnt", WAKE_CNT, 8'd1);

        // Interrupted settle: A3 pulse seen by the FSM while CNT=2
        A1 = 1'b0;
        tick();
        tick();
        A3 = 1'b1;
        tick();
        A3 = 1'b0;
        for (int e = 4; e <= 8; e++) begin
            tick();
            chk("intr_idle_low", {7'd0, IDLE}, 8'd0);
            chk("intr_wake", {7'd0, WAKE}, 8'd0);
        end
        tick();
        chk("intr_idle_e9", {7'd0, IDLE}, 8'd1);
        chk("intr_cnt", WAKE_CNT, 8'd1);

        // EN falls and A2 rises together: no WAKE
        EN = 1'b0;
        A2 = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            tick();
            chk("simul_idle", {7'd0, IDLE}, 8'd0);
            chk("simul_wake", {7'd0, WAKE}, 8'd0);
            chk("simul_cnt", WAKE_CNT, 8'd1);
        end

        // Reset during SETTLE with CNT=3
        EN = 1'b1;
        A2 = 1'b0;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk("pre_rst_idle", {7'd0, IDLE}, 8'd0);
        end
        #2;
        RN = 1'b0;
        #1;
        chk("midrst_idle", {7'd0, IDLE}, 8'd0);
        chk("midrst_wake", {7'd0, WAKE}, 8'd0);
        chk("midrst_cnt", WAKE_CNT, 8'd0);
        tick();
        chk("midrst_hold_idle", {7'd0, IDLE}, 8'd0);
        RN = 1'b1;
        qualify("requal");

        // Saturation over 260 wake cycles
        for (int n = 1; n <= 260; n++) begin
            A1 = 1'b1;
            tick();
            tick();
            chk("sat_pre_wake", {7'd0, WAKE}, 8'd0);
            tick();
            chk("sat_wake", {7'd0, WAKE}, 8'd1);
            chk("sat_cnt", WAKE_CNT, (n < 255) ? 8'(n) : 8'd255);
            A1 = 1'b0;
            for (int e = 1; e <= 5; e++) begin
                tick();
            end
            chk("sat_wake_off", {7'd0, WAKE}, 8'd0);
            tick();
            chk("sat_idle", {7'd0, IDLE}, 8'd1);
        end
        chk("sat_final_cnt", WAKE_CNT, 8'd255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
